barrier_ctrl: RTL and testbench
===============================

Name: barrier_ctrl

Overview:
- Per-core warp barrier controller. Consumes barrier requests issued by warps (valid / id / size_m1, as carried by the GPU barrier record) and tracks arrivals per barrier ID.
- Holds arriving warps stalled until the expected number of warps has arrived, then emits a one-shot release mask to the warp scheduler.
- Sits between the GPU functional unit (request side) and the warp scheduler (stall/release side).

Parameters:
- NUM_WARPS, 4, warps per core.
- NUM_BARRIERS, 4, barrier IDs supported.
- NW_BITS, clog2(NUM_WARPS) (min 1), warp-index / count width.
- NB_BITS, clog2(NUM_BARRIERS) (min 1), barrier-ID width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- bar_valid  in  1  barrier request valid.
- bar_ready  out  1  request accepted when valid && ready.
- bar_wid  in  NW_BITS  requesting warp index.
- bar_id  in  NB_BITS  barrier ID.
- bar_size_m1  in  NW_BITS  participating warps minus one.
- rel_valid  out  1  release pending.
- rel_ready  in  1  scheduler accepts release.
- rel_mask  out  NUM_WARPS  warps to release.
- stalled_mask  out  NUM_WARPS  warps currently parked at any barrier.
- active_mask  out  NUM_BARRIERS  barriers with at least one waiter.

Behaviour:
- Reset (async assert, sync deassert): all per-barrier count, size, wait_mask = 0; rel_valid=0, rel_mask=0, stalled_mask=0, active_mask=0.
- Per-barrier state: count (NW_BITS), size_m1 (NW_BITS, latched on first arrival), wait_mask (NUM_WARPS).
- bar_ready = !rel_valid || rel_ready. Combinational; only one release can be pending.
- Accept (bar_valid && bar_ready), barrier b = bar_id:
  - Effective size: if active_mask[b]=0, eff = bar_size_m1 and it is latched into size_m1[b]. Otherwise eff = latched size_m1[b]; mismatched later sizes are ignored.
  - If count[b] == eff: release. Next edge: rel_valid=1, rel_mask = wait_mask[b] | onehot(bar_wid), count[b]=0, wait_mask[b]=0, active_mask[b]=0. Clear those stalled_mask bits on the same edge. The requesting warp is never marked stalled.
  - Else: next edge: count[b]++, wait_mask[b][bar_wid]=1, stalled_mask[bar_wid]=1, active_mask[b]=1.
- size_m1=0: immediate single-warp release, rel_mask=onehot(bar_wid), one cycle latency.
- Release handshake: rel_valid/rel_mask hold stable until rel_ready. On rel_valid && rel_ready with no new release, rel_valid drops next edge and rel_mask goes to 0.
- Back-to-back releases: if rel_ready=1 and an accepted request triggers a new release in the same cycle, rel_valid stays 1 and rel_mask loads the new mask (no bubble).
- Request from a warp already set in stalled_mask: protocol error. Simulation assertion fires; RTL behaviour undefined.
- count never exceeds NUM_WARPS-1; no wrap is possible under legal use.
- Releases on different barriers are independent; state of non-addressed barriers is untouched.
- Reset mid-operation: all waiters are dropped and the pending release is lost. The scheduler is reset concurrently.
- Latency: request accept to rel_valid = 1 cycle; to stalled_mask update = 1 cycle.

Test Plan:
- Reset: hold reset_n=0 with bar_valid toggling -> all outputs 0. After release, bar_ready=1.
- 4-warp barrier: id=1, size_m1=3, warps 0,1,2 on cycles 1-3 -> stalled_mask=0b0111, active_mask=0b0010. Warp 3 on cycle 4 -> cycle 5 rel_valid=1, rel_mask=0b1111, stalled_mask=0, active_mask=0.
- Backpressure: rel_ready=0 during pending release -> bar_ready=0, rel_mask held 3 cycles. rel_ready=1 -> rel_valid drops next cycle.
- Trivial barrier: size_m1=0, warp 2, id 0 -> next cycle rel_mask=0b0100. stalled_mask stays 0.
- Interleaved barriers: id0 size_m1=1 (warps 0,1), id3 size_m1=1 (warps 2,3), alternating arrivals -> two separate releases, rel_mask 0b0011 then 0b1100, with no bubble when rel_ready=1.
- Size mismatch: warp 0 id2 size_m1=1, then warp 1 id2 size_m1=3 -> release after warp 1, rel_mask=0b0011.

Source files
------------

// File: rtl/barrier_if.sv
// Barrier request / release bundle between the
// functional unit, the barrier controller and the scheduler.
interface barrier_if #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
);
  logic                    bar_valid;
  logic                    bar_ready;
  logic [NW_BITS-1:0]      bar_wid;
  logic [NB_BITS-1:0]      bar_id;
  logic [NW_BITS-1:0]      bar_size_m1;
  logic                    rel_valid;
  logic                    rel_ready;
  logic [NUM_WARPS-1:0]    rel_mask;
  logic [NUM_WARPS-1:0]    stalled_mask;
  logic [NUM_BARRIERS-1:0] active_mask;

  modport master (
    output bar_valid, bar_wid, bar_id, bar_size_m1, rel_ready,
    input  bar_ready, rel_valid, rel_mask, stalled_mask, active_mask
  );

  modport slave (
    input  bar_valid, bar_wid, bar_id, bar_size_m1, rel_ready,
    output bar_ready, rel_valid, rel_mask, stalled_mask, active_mask
  );
endinterface

// File: rtl/barrier_ctrl.sv
// Per-core warp barrier controller: counts arrivals per
// barrier ID and emits a one-shot release mask.
module barrier_ctrl #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input logic      clk,
  input logic      reset_n,
  barrier_if.slave bif
);

  logic [NW_BITS-1:0]      count_q [NUM_BARRIERS];
  logic [NW_BITS-1:0]      count_d [NUM_BARRIERS];
  logic [NW_BITS-1:0]      size_q  [NUM_BARRIERS];
  logic [NW_BITS-1:0]      size_d  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]    wait_q  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]    wait_d  [NUM_BARRIERS];
  logic [NUM_BARRIERS-1:0] active_q, active_d;
  logic [NUM_WARPS-1:0]    stalled_q, stalled_d;
  logic [NUM_WARPS-1:0]    rel_mask_q, rel_mask_d;
  logic                    rel_valid_q, rel_valid_d;

  logic                    bar_ready;
  logic                    accept;
  logic [NW_BITS-1:0]      eff;
  logic                    hit;
  logic [NUM_WARPS-1:0]    wid_oh;

  assign bar_ready = !rel_valid_q || bif.rel_ready;
  assign accept    = bif.bar_valid && bar_ready;
  assign eff       = active_q[bif.bar_id] ? size_q[bif.bar_id]
                                          : bif.bar_size_m1;
  assign hit       = count_q[bif.bar_id] == eff;
  assign wid_oh    = NUM_WARPS'(1) << bif.bar_wid;

  assign bif.bar_ready    = bar_ready;
  assign bif.rel_valid    = rel_valid_q;
  assign bif.rel_mask     = rel_mask_q;
  assign bif.stalled_mask = stalled_q;
  assign bif.active_mask  = active_q;

  // Next state: retire the pending release, then apply any arrival.
  always_comb begin
    count_d     = count_q;
    size_d      = size_q;
    wait_d      = wait_q;
    active_d    = active_q;
    stalled_d   = stalled_q;
    rel_mask_d  = rel_mask_q;
    rel_valid_d = rel_valid_q;
    if (rel_valid_q && bif.rel_ready) begin
      rel_valid_d = 1'b0;
      rel_mask_d  = '0;
    end
    if (accept) begin
      if (!active_q[bif.bar_id])
        size_d[bif.bar_id] = bif.bar_size_m1;
      if (hit) begin
        rel_valid_d           = 1'b1;
        rel_mask_d            = wait_q[bif.bar_id] | wid_oh;
        count_d[bif.bar_id]   = '0;
        wait_d[bif.bar_id]    = '0;
        active_d[bif.bar_id]  = 1'b0;
        stalled_d             = stalled_q & ~wait_q[bif.bar_id];
      end else begin
        count_d[bif.bar_id]   = count_q[bif.bar_id] + NW_BITS'(1);
        wait_d[bif.bar_id]    = wait_q[bif.bar_id] | wid_oh;
        active_d[bif.bar_id]  = 1'b1;
        stalled_d             = stalled_q | wid_oh;
      end
    end
  end

  // State registers; reset drops all waiters and any pending release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        count_q[b] <= '0;
        size_q[b]  <= '0;
        wait_q[b]  <= '0;
      end
      active_q    <= '0;
      stalled_q   <= '0;
      rel_mask_q  <= '0;
      rel_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      size_q      <= size_d;
      wait_q      <= wait_d;
      active_q    <= active_d;
      stalled_q   <= stalled_d;
      rel_mask_q  <= rel_mask_d;
      rel_valid_q <= rel_valid_d;
    end
  end

  // A warp already parked at a barrier must not issue another request.
  a_no_double_arrive: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(accept && stalled_q[bif.bar_wid])
  );

endmodule

// File: tb/tb_barrier_ctrl.sv
// Directed testbench for barrier_ctrl.
// Inputs driven #1 after posedge; outputs checked there.
module tb_barrier_ctrl;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  barrier_if #(.NUM_WARPS(4), .NUM_BARRIERS(4)) bif ();

  barrier_ctrl #(.NUM_WARPS(4), .NUM_BARRIERS(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bif     (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int wid, input int id, input int sz);
    bif.bar_valid   = 1'b1;
    bif.bar_wid     = 2'(wid);
    bif.bar_id      = 2'(id);
    bif.bar_size_m1 = 2'(sz);
    step();
    bif.bar_valid   = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bif.bar_valid   = i[0];
      bif.bar_wid     = 2'(i);
      bif.bar_id      = 2'(i);
      bif.bar_size_m1 = 2'(3 - i);
      step();
      n_checks++;
      if (bif.rel_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_rel_valid got %b exp 0", bif.rel_valid);
      end
      n_checks++;
      if (bif.rel_mask !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_rel_mask got %b exp 0000", bif.rel_mask);
      end
      n_checks++;
      if (bif.stalled_mask !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_stalled got %b exp 0000", bif.stalled_mask);
      end
      n_checks++;
      if (bif.active_mask !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_active got %b exp 0000", bif.active_mask);
      end
    end
    bif.bar_valid = 1'b0;
    reset_n = 1'b1;
    step();
    n_checks++;
    if (bif.bar_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_bar_ready got %b exp 1", bif.bar_ready);
    end
  endtask

  task automatic test_four_warp();
    bif.rel_ready = 1'b1;
    req(0, 1, 3);
    req(1, 1, 3);
    req(2, 1, 3);
    n_checks++;
    if (bif.stalled_mask !== 4'b0111) begin
      n_fail++;
      $display("FAIL four_stalled got %b exp 0111", bif.stalled_mask);
    end
    n_checks++;
    if (bif.active_mask !== 4'b0010) begin
      n_fail++;
      $display("FAIL four_active got %b exp 0010", bif.active_mask);
    end
    n_checks++;
    if (bif.rel_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL four_early_rel got %b exp 0", bif.rel_valid);
    end
    req(3, 1, 3);
    n_checks++;
    if (bif.rel_valid !== 1'b1 || bif.rel_mask !== 4'b1111) begin
      n_fail++;
      $display("FAIL four_release got v=%b m=%b exp v=1 m=1111",
               bif.rel_valid, bif.rel_mask);
    end
    n_checks++;
    if (bif.stalled_mask !== 4'b0000 || bif.active_mask !== 4'b0000) begin
      n_fail++;
      $display("FAIL four_cleared got s=%b a=%b exp 0000/0000",
               bif.stalled_mask, bif.active_mask);
    end
    step();
    n_checks++;
    if (bif.rel_valid !== 1'b0 || bif.rel_mask !== 4'b0000) begin
      n_fail++;
      $display("FAIL four_drop got v=%b m=%b exp v=0 m=0000",
               bif.rel_valid, bif.rel_mask);
    end
  endtask

  task automatic test_backpressure();
    bif.rel_ready = 1'b0;
    req(0, 2, 1);
    req(1, 2, 1);
    bif.bar_valid   = 1'b1;
    bif.bar_wid     = 2'd3;
    bif.bar_id      = 2'd3;
    bif.bar_size_m1 = 2'd1;
    #1;
    n_checks++;
    if (bif.bar_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ready_low got %b exp 0", bif.bar_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (bif.rel_valid !== 1'b1 || bif.rel_mask !== 4'b0011) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got v=%b m=%b exp v=1 m=0011",
                 i, bif.rel_valid, bif.rel_mask);
      end
      n_checks++;
      if (bif.stalled_mask !== 4'b0000 || bif.active_mask !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_no_accept[%0d] got s=%b a=%b exp 0000/0000",
                 i, bif.stalled_mask, bif.active_mask);
      end
    end
    bif.bar_valid = 1'b0;
    bif.rel_ready = 1'b1;
    #1;
    n_checks++;
    if (bif.bar_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_high got %b exp 1", bif.bar_ready);
    end
    step();
    n_checks++;
    if (bif.rel_valid !== 1'b0 || bif.rel_mask !== 4'b0000) begin
      n_fail++;
      $display("FAIL bp_drop got v=%b m=%b exp v=0 m=0000",
               bif.rel_valid, bif.rel_mask);
    end
  endtask

  task automatic test_trivial();
    req(2, 0, 0);
    n_checks++;
    if (bif.rel_valid !== 1'b1 || bif.rel_mask !== 4'b0100) begin
      n_fail++;
      $display("FAIL triv_release got v=%b m=%b exp v=1 m=0100",
               bif.rel_valid, bif.rel_mask);
    end
    n_checks++;
    if (bif.stalled_mask !== 4'b0000 || bif.active_mask !== 4'b0000) begin
      n_fail++;
      $display("FAIL triv_state got s=%b a=%b exp 0000/0000",
               bif.stalled_mask, bif.active_mask);
    end
    step();
    n_checks++;
    if (bif.rel_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL triv_drop got %b exp 0", bif.rel_valid);
    end
  endtask

  task automatic test_back_to_back();
    req(0, 0, 1);
    req(2, 3, 1);
    n_checks++;
    if (bif.stalled_mask !== 4'b0101 || bif.active_mask !== 4'b1001) begin
      n_fail++;
      $display("FAIL b2b_wait got s=%b a=%b exp 0101/1001",
               bif.stalled_mask, bif.active_mask);
    end
    req(1, 0, 1);
    n_checks++;
    if (bif.rel_valid !== 1'b1 || bif.rel_mask !== 4'b0011) begin
      n_fail++;
      $display("FAIL b2b_rel0 got v=%b m=%b exp v=1 m=0011",
               bif.rel_valid, bif.rel_mask);
    end
    n_checks++;
    if (bif.stalled_mask !== 4'b0100 || bif.active_mask !== 4'b1000) begin
      n_fail++;
      $display("FAIL b2b_mid got s=%b a=%b exp 0100/1000",
               bif.stalled_mask, bif.active_mask);
    end
    req(3, 3, 1);
    n_checks++;
    if (bif.rel_valid !== 1'b1 || bif.rel_mask !== 4'b1100) begin
      n_fail++;
      $display("FAIL b2b_rel3 got v=%b m=%b exp v=1 m=1100",
               bif.rel_valid, bif.rel_mask);
    end
    n_checks++;
    if (bif.stalled_mask !== 4'b0000 || bif.active_mask !== 4'b0000) begin
      n_fail++;
      $display("FAIL b2b_end got s=%b a=%b exp 0000/0000",
               bif.stalled_mask, bif.active_mask);
    end
    step();
    n_checks++;
    if (bif.rel_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drop got %b exp 0", bif.rel_valid);
    end
  endtask

  task automatic test_size_mismatch();
    req(0, 2, 1);
    n_checks++;
    if (bif.rel_valid !== 1'b0 || bif.stalled_mask !== 4'b0001) begin
      n_fail++;
      $display("FAIL mis_first got v=%b s=%b exp v=0 s=0001",
               bif.rel_valid, bif.stalled_mask);
    end
    req(1, 2, 3);
    n_checks++;
    if (bif.rel_valid !== 1'b1 || bif.rel_mask !== 4'b0011) begin
      n_fail++;
      $display("FAIL mis_release got v=%b m=%b exp v=1 m=0011",
               bif.rel_valid, bif.rel_mask);
    end
    step();
  endtask

  task automatic test_reset_mid();
    req(0, 1, 3);
    req(1, 1, 3);
    n_checks++;
    if (bif.stalled_mask !== 4'b0011) begin
      n_fail++;
      $display("FAIL rmid_pre got %b exp 0011", bif.stalled_mask);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bif.stalled_mask !== 4'b0000 || bif.active_mask !== 4'b0000) begin
      n_fail++;
      $display("FAIL rmid_async got s=%b a=%b exp 0000/0000",
               bif.stalled_mask, bif.active_mask);
    end
    step();
    reset_n = 1'b1;
    req(2, 1, 1);
    n_checks++;
    if (bif.rel_valid !== 1'b0 || bif.stalled_mask !== 4'b0100) begin
      n_fail++;
      $display("FAIL rmid_fresh got v=%b s=%b exp v=0 s=0100",
               bif.rel_valid, bif.stalled_mask);
    end
    req(3, 1, 1);
    n_checks++;
    if (bif.rel_valid !== 1'b1 || bif.rel_mask !== 4'b1100) begin
      n_fail++;
      $display("FAIL rmid_rel got v=%b m=%b exp v=1 m=1100",
               bif.rel_valid, bif.rel_mask);
    end
    step();
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    reset_n         = 1'b0;
    bif.bar_valid   = 1'b0;
    bif.bar_wid     = '0;
    bif.bar_id      = '0;
    bif.bar_size_m1 = '0;
    bif.rel_ready   = 1'b1;
    test_reset();
    test_four_warp();
    test_backpressure();
    test_trivial();
    test_back_to_back();
    test_size_mismatch();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
